// File: rtl/softmax_div_sched_if.sv
// Handshake bundle for the softmax divide scheduler: denominator, numerator
// and quotient channels.
interface softmax_div_sched_if;
  logic        den_valid;
  logic        den_ready;
  logic [31:0] den;
  logic        num_valid;
  logic        num_ready;
  logic [63:0] num;
  logic        q_valid;
  logic        q_ready;
  logic [7:0]  q;
  logic        q_last;

  modport master (
    output den_valid, den, num_valid, num, q_ready,
    input  den_ready, num_ready, q_valid, q, q_last
  );

  modport slave (
    input  den_valid, den, num_valid, num, q_ready,
    output den_ready, num_ready, q_valid, q, q_last
  );
endinterface

// File: rtl/softmax_div_sched.sv
// Feeds a combinational log-domain divider with one denominator and N
// numerators per softmax vector through a two-stage pipeline.
module softmax_div_sched #(
  parameter int          N      = 8,
  parameter int unsigned POS_NU = 16,
  parameter int unsigned POS_DE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  softmax_div_sched_if.slave   bus,
  output logic [63:0]          div_num,
  output logic [31:0]          div_den,
  output logic [5:0]           div_lod_nu,
  output logic [4:0]           div_lod_de,
  output logic [4:0]           div_pos_nu,
  output logic [4:0]           div_pos_de,
  input  logic [7:0]           div_quo,
  output logic                 busy,
  output logic                 den_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  localparam logic [7:0] LAST_IDX = 8'(N - 1);

  function automatic logic [5:0] lod64(input logic [63:0] v);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) r = 6'(i);
      else      r = r;
    end
    return r;
  endfunction

  function automatic logic [4:0] lod32(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 5'(i);
      else      r = r;
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] den_q, den_d;
  logic [4:0]  lod_de_q, lod_de_d;
  logic        den_zero_q, den_zero_d;
  logic [7:0]  count_q, count_d;
  logic [63:0] num_q, num_d;
  logic [5:0]  lod_nu_q, lod_nu_d;
  logic        nz_q, nz_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s1_last_q, s1_last_d;
  logic [7:0]  q_q, q_d;
  logic        q_valid_q, q_valid_d;
  logic        q_last_q, q_last_d;
  logic        busy_q, busy_d;
  logic        rdy_en_q;

  logic s1_advance, den_fire, num_fire, q_fire;

  // rdy_en_q keeps both ready lines low until the first edge out of reset.
  always_comb begin
    s1_advance    = !q_valid_q || bus.q_ready;
    bus.den_ready = rdy_en_q && (state_q == IDLE);
    bus.num_ready = rdy_en_q && (state_q == RUN) && (!s1_valid_q || s1_advance);
    den_fire      = bus.den_valid && bus.den_ready;
    num_fire      = bus.num_valid && bus.num_ready;
    q_fire        = q_valid_q && bus.q_ready;
  end

  always_comb begin
    state_d    = state_q;
    den_d      = den_q;
    lod_de_d   = lod_de_q;
    den_zero_d = den_zero_q;
    count_d    = count_q;
    num_d      = num_q;
    lod_nu_d   = lod_nu_q;
    nz_d       = nz_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    q_last_d   = q_last_q;

    case (state_q)
      IDLE: begin
        if (den_fire) begin
          den_d      = bus.den;
          lod_de_d   = lod32(bus.den);
          den_zero_d = (bus.den == 32'd0);
          count_d    = 8'd0;
          state_d    = RUN;
        end else begin
          state_d    = IDLE;
        end
      end
      RUN: begin
        if (num_fire && (count_q == LAST_IDX)) state_d = DRAIN;
        else                                   state_d = RUN;
      end
      DRAIN: begin
        if (q_fire && q_last_q) state_d = IDLE;
        else                    state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase

    if (num_fire) begin
      num_d      = bus.num;
      lod_nu_d   = lod64(bus.num);
      nz_d       = (bus.num != 64'd0);
      s1_last_d  = (count_q == LAST_IDX);
      count_d    = count_q + 8'd1;
      s1_valid_d = 1'b1;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // Stage 2 captures the divider result while stage 1 holds its operands.
    if (s1_valid_q && s1_advance) begin
      q_d       = den_zero_q ? 8'hFF : (nz_q ? div_quo : 8'h00);
      q_valid_d = 1'b1;
      q_last_d  = s1_last_q;
    end else if (q_fire) begin
      q_valid_d = 1'b0;
      q_last_d  = 1'b0;
    end else begin
      q_valid_d = q_valid_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      den_q      <= 32'd0;
      lod_de_q   <= 5'd0;
      den_zero_q <= 1'b0;
      count_q    <= 8'd0;
      num_q      <= 64'd0;
      lod_nu_q   <= 6'd0;
      nz_q       <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      q_q        <= 8'h00;
      q_valid_q  <= 1'b0;
      q_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      den_q      <= den_d;
      lod_de_q   <= lod_de_d;
      den_zero_q <= den_zero_d;
      count_q    <= count_d;
      num_q      <= num_d;
      lod_nu_q   <= lod_nu_d;
      nz_q       <= nz_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      q_last_q   <= q_last_d;
      busy_q     <= busy_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign div_num    = num_q;
  assign div_den    = den_q;
  assign div_lod_nu = lod_nu_q;
  assign div_lod_de = lod_de_q;
  assign div_pos_nu = 5'(POS_NU);
  assign div_pos_de = 5'(POS_DE);

  assign bus.q_valid = q_valid_q;
  assign bus.q       = q_q;
  assign bus.q_last  = q_last_q;
  assign busy        = busy_q;
  assign den_zero    = den_zero_q;

endmodule

// File: tb/tb_softmax_div_sched.sv
// Scoreboard bench for softmax_div_sched: directed vectors plus randomized
// traffic, checked against a value-level model of the schedule.
module tb_softmax_div_sched;
  localparam int N      = 4;
  localparam int POS_NU = 16;
  localparam int POS_DE = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softmax_div_sched_if bus();
  logic [63:0] div_num;
  logic [31:0] div_den;
  logic [5:0]  div_lod_nu;
  logic [4:0]  div_lod_de, div_pos_nu, div_pos_de;
  logic [7:0]  div_quo;
  logic        busy, den_zero;

  // Stand-in divider: an arbitrary mix of every operand so wiring errors show.
  function automatic logic [7:0] div_fn(input logic [63:0] n, input logic [31:0] d,
                                        input logic [5:0] ln, input logic [4:0] ld,
                                        input logic [4:0] pn, input logic [4:0] pd);
    logic [7:0] r;
    r = n[7:0] ^ n[63:56] ^ n[35:28];
    r = r + d[7:0] + d[31:24] + {ln, 2'b01} - {ld, 3'b000};
    r = r ^ {3'b000, pn} ^ {pd, 3'b101};
    return r;
  endfunction

  function automatic int msb(input logic [64:0] x);
    return (x == 65'd0) ? 0 : $clog2(x + 65'd1) - 1;
  endfunction

  always_comb div_quo = div_fn(div_num, div_den, div_lod_nu, div_lod_de, div_pos_nu, div_pos_de);

  softmax_div_sched #(.N(N), .POS_NU(POS_NU), .POS_DE(POS_DE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .div_num(div_num), .div_den(div_den), .div_lod_nu(div_lod_nu),
    .div_lod_de(div_lod_de), .div_pos_nu(div_pos_nu), .div_pos_de(div_pos_de),
    .div_quo(div_quo), .busy(busy), .den_zero(den_zero)
  );

  typedef struct packed { logic [7:0] q; logic last; } exp_t;
  exp_t exp_q[$];
  int   acc_cyc[$];
  int   xfer_cyc[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  logic [31:0] m_den = 32'd0;
  logic m_dz = 1'b0;
  int   m_idx = 0;
  bit   rand_ready = 1'b0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // q_ready source: forced stall window, random, or always ready
  initial begin
    bus.q_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_cnt > 0) begin
        bus.q_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready) begin
        bus.q_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.q_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each quotient transfer, checks hold stability
  initial begin
    exp_t e;
    logic held_v;
    logic [7:0] held_q;
    logic held_l;
    held_v = 1'b0;
    held_q = 8'h00;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("hold_valid", 64'(bus.q_valid), 64'd1);
          check("hold_q", 64'({bus.q, bus.q_last}), 64'({held_q, held_l}));
        end
        held_v = 1'b0;
        if (bus.q_valid && exp_q.size() == 0) begin
          timeout("spurious_q_valid");
        end else if (bus.q_valid && bus.q_ready) begin
          e = exp_q.pop_front();
          check("q", 64'(bus.q), 64'(e.q));
          check("q_last", 64'(bus.q_last), 64'(e.last));
          xfer_cyc.push_back(cyc + 1);
        end else if (bus.q_valid) begin
          held_v = 1'b1;
          held_q = bus.q;
          held_l = bus.q_last;
        end
      end
    end
  end

  task automatic send_den(input logic [31:0] v);
    int t = 0;
    @(negedge clk);
    bus.den_valid = 1'b1;
    bus.den = v;
    #1;
    while (!bus.den_ready && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.den_ready) begin
      timeout("den_accept");
    end else begin
      m_den = v;
      m_dz = (v == 32'd0);
      m_idx = 0;
    end
    @(posedge clk);
    #1;
    bus.den_valid = 1'b0;
  endtask

  task automatic send_num(input logic [63:0] v);
    int t = 0;
    exp_t e;
    @(negedge clk);
    bus.num_valid = 1'b1;
    bus.num = v;
    #1;
    while (!bus.num_ready && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.num_ready) begin
      timeout("num_accept");
    end else begin
      if (m_dz)             e.q = 8'hFF;
      else if (v == 64'd0)  e.q = 8'h00;
      else e.q = div_fn(v, m_den, 6'(msb({1'b0, v})), 5'(msb({33'd0, m_den})),
                        5'(POS_NU), 5'(POS_DE));
      e.last = (m_idx == N - 1);
      exp_q.push_back(e);
      acc_cyc.push_back(cyc + 1);
      m_idx++;
    end
    @(posedge clk);
    #1;
    bus.num_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      #3;
      t++;
    end
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_den_ready", 64'(bus.den_ready), 64'd1);
  endtask

  function automatic logic [63:0] rand_num();
    logic [63:0] v;
    v = {$urandom, $urandom};
    v = v >> $urandom_range(0, 63);
    if ($urandom_range(0, 6) == 0) v = 64'd0;
    return v;
  endfunction

  initial begin
    logic [63:0] v4[4];
    logic [31:0] d;
    int t;
    bus.den_valid = 1'b0;
    bus.den = 32'd0;
    bus.num_valid = 1'b0;
    bus.num = 64'd0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_den_ready", 64'(bus.den_ready), 64'd0);
    check("rst_num_ready", 64'(bus.num_ready), 64'd0);
    check("rst_q_valid", 64'(bus.q_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_den_zero", 64'(den_zero), 64'd0);
    check("rst_q", 64'(bus.q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_den_ready_low", 64'(bus.den_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_den_ready_high", 64'(bus.den_ready), 64'd1);

    // Basic vector with back-to-back quotients
    v4[0] = 64'h1000; v4[1] = 64'h800; v4[2] = 64'h400; v4[3] = 64'h200;
    acc_cyc.delete();
    xfer_cyc.delete();
    send_den(32'h100);
    for (int i = 0; i < 4; i++) send_num(v4[i]);
    wait_idle();
    check("n_xfer", 64'(xfer_cyc.size()), 64'd4);
    if (xfer_cyc.size() == 4 && acc_cyc.size() == 4) begin
      check("latency", 64'(xfer_cyc[0] - acc_cyc[0]), 64'd2);
      for (int i = 1; i < 4; i++) begin
        check("b2b_num", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd1);
        check("b2b_q", 64'(xfer_cyc[i] - xfer_cyc[i-1]), 64'd1);
      end
    end

    // Same vector with a 5-cycle stall after the first quotient
    send_den(32'h100);
    fork
      begin
        for (int i = 0; i < 4; i++) send_num(v4[i]);
      end
      begin
        t = 0;
        while (!bus.q_valid && t < 50) begin
          @(posedge clk);
          #1;
          t++;
        end
        stall_cnt = 5;
        @(negedge clk);
        #1;
        check("bp_num_ready", 64'(bus.num_ready), 64'd0);
        check("bp_q_valid", 64'(bus.q_valid), 64'd1);
      end
    join
    wait_idle();

    // Zero numerator mid-vector
    send_den(32'h3000);
    send_num(64'h1234);
    send_num(64'd0);
    send_num(64'h55);
    send_num(64'h8000_0000_0000);
    wait_idle();

    // Zero denominator, then recovery with den=1
    send_den(32'd0);
    check("den_zero_set", 64'(den_zero), 64'd1);
    for (int i = 0; i < N; i++) send_num(rand_num() | 64'd1);
    wait_idle();
    check("den_zero_sticky", 64'(den_zero), 64'd1);
    send_den(32'd1);
    check("den_zero_clear", 64'(den_zero), 64'd0);
    for (int i = 0; i < N; i++) send_num(rand_num());
    wait_idle();

    // Reset after two numerators discards in-flight work
    send_den(32'h40);
    send_num(64'h9999);
    send_num(64'h7777);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_q_valid", 64'(bus.q_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_num_ready", 64'(bus.num_ready), 64'd0);
    check("mid_rst_den_ready", 64'(bus.den_ready), 64'd0);
    @(negedge clk);
    exp_q.delete();
    m_idx = 0;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("post_rst_q_valid", 64'(bus.q_valid), 64'd0);
    end
    send_den(32'h40);
    for (int i = 0; i < N; i++) send_num(rand_num());
    wait_idle();

    // num_valid in IDLE and den_valid in RUN are ignored
    @(negedge clk);
    bus.num_valid = 1'b1;
    bus.num = 64'hABCD;
    repeat (3) begin
      #1;
      check("idle_num_ready", 64'(bus.num_ready), 64'd0);
      check("idle_busy_hold", 64'(busy), 64'd0);
      @(negedge clk);
    end
    bus.num_valid = 1'b0;
    send_den(32'h77);
    send_num(64'h3210);
    @(negedge clk);
    bus.den_valid = 1'b1;
    bus.den = 32'h5;
    repeat (3) begin
      #1;
      check("run_den_ready", 64'(bus.den_ready), 64'd0);
      check("run_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    bus.den_valid = 1'b0;
    for (int i = 1; i < N; i++) send_num(rand_num());
    wait_idle();

    // Randomized vectors with random backpressure and gaps
    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 4) == 0) d = 32'd0;
      send_den(d);
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_num(rand_num());
      end
      wait_idle();
      check("rand_den_zero", 64'(den_zero), 64'(d == 32'd0));
    end
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
